bcd_display_latch: RTL and testbench
====================================

// Module: bcd_display_latch
// PURPOSE
//  Parametrised display register between the BCD counter chain and the 7-segment decoder.
//  - On each enable strobe, captures DIGITS BCD digits.
//  - Detects overload and shows a fixed overload pattern, held until an explicit clear.
//  - Optionally blanks leading zeros.
//  - Rejects non-BCD input and pulses a valid strobe toward the display mux.
// PARAMETERS
//  DIGITS      4      number of BCD digits (2..8)
//  LZB         1      1 = leading-zero blanking enabled, 0 = raw digits
//  BLANK_CODE  4'hE   code driven on a blanked digit (decoder renders it dark)
//  OVL_TOP     4'h1   code on the most significant digit during overload
//  OVL_FILL    4'hF   code on all other digits during overload
// PORTS
//  i_CLK      in   1          system clock, rising edge
//  i_Rst_n    in   1          asynchronous active-low reset
//  i_En       in   1          latch strobe, one-cycle pulse from gate timer
//  i_Hold     in   1          freeze display; i_En ignored while high
//  i_Clr      in   1          synchronous clear of display, overload and error
//  i_Ovf      in   1          carry-out of counter chain (external overload)
//  i_Count    in   4*DIGITS   BCD digits, digit 0 in [3:0] (LSD)
//  o_Q        out  4*DIGITS   display codes, same packing as i_Count
//  o_Valid    out  1          one-cycle pulse: o_Q was updated this edge
//  o_Ovl      out  1          overload state active (sticky)
//  o_Err      out  1          non-BCD digit seen on a strobe (sticky)
// BEHAVIOUR
//  Reset (i_Rst_n=0, async): state=S_RUN, o_Valid=0, o_Ovl=0, o_Err=0.
//   o_Q: digit0=0. Other digits = BLANK_CODE if LZB=1, else 0.
//  Sampling: inputs sampled at rising edge k; o_Q/o_Valid/o_Ovl/o_Err registered, valid after edge k.
//  Priority per edge: i_Clr > i_Hold > i_En.
//  States: S_RUN (display follows strobes), S_OVL (overload pattern frozen).
//  i_Clr (any state): o_Q := reset value, o_Ovl:=0, o_Err:=0, state:=S_RUN, o_Valid:=0.
//   Concurrent i_En is discarded.
//  i_Hold=1 and no i_Clr: all registers keep value; o_Valid=0.
//  S_RUN, i_En=1, i_Hold=0, checks in this order:
//   a) Any digit >9: o_Q unchanged, o_Err:=1, o_Valid=0, stay S_RUN.
//   b) Else all digits ==9, or i_Ovf=1:
//      - o_Q: MSD=OVL_TOP, all others=OVL_FILL.
//      - o_Ovl:=1, o_Valid:=1, state:=S_OVL.
//   c) Else o_Q:=i_Count, with blanking if LZB=1, then o_Valid:=1.
//      Blanking: digits above the highest nonzero digit become BLANK_CODE.
//      Digit 0 is never blanked (value 0 shows as a single 0).
//  S_OVL: i_En ignored (o_Valid=0, o_Err unchanged). Exit only via i_Clr or reset.
//  o_Valid is high exactly one cycle per accepted strobe; back-to-back strobes give back-to-back pulses.
//  o_Err and o_Ovl are independent; both may be set.
//  Reset mid-operation: immediate return to reset values, no pending strobe survives.
// TESTING
//  1. Reset, DIGITS=4, LZB=1; strobe i_Count=16'h0042 -> next cycle o_Q=16'hEE42, o_Valid=1 for 1 cycle.
//  2. Strobe i_Count=16'h9999 -> o_Q=16'h1FFF, o_Ovl=1.
//     Then strobe 16'h0001 -> o_Q stays 16'h1FFF, o_Valid=0.
//     Then i_Clr -> o_Q=16'hEEE0, o_Ovl=0.
//  3. Strobe i_Count=16'h12A4 -> o_Q unchanged, o_Err=1, o_Valid=0.
//     Next strobe 16'h0305 -> o_Q=16'hE305, o_Err still 1.
//  4. i_Hold=1 with strobe 16'h0777 -> no change, o_Valid=0.
//     i_Hold=0 with strobe 16'h0777 -> o_Q=16'hE777.
//     Same-cycle i_Clr+i_En -> clear wins.
//  5. Strobe 16'h0000 with i_Ovf=1 -> overload pattern.
//     Strobe 16'h0000 with i_Ovf=0, after clear -> o_Q=16'hEEE0.
//     LZB=0 build, same strobe -> o_Q=16'h0000.
//  6. Assert i_Rst_n=0 mid-cycle while in S_OVL -> outputs reset asynchronously before next edge.
//     Repeat test 1 with DIGITS=6.

Source files
------------

// File: rtl/bcd_display_latch.sv
// Display register between the BCD counter chain and the 7-segment decoder:
// latches digits on a strobe, shows a sticky overload pattern, blanks leading zeros.
module bcd_display_latch #(
  parameter int         DIGITS     = 4,
  parameter bit         LZB        = 1'b1,
  parameter logic [3:0] BLANK_CODE = 4'hE,
  parameter logic [3:0] OVL_TOP    = 4'h1,
  parameter logic [3:0] OVL_FILL   = 4'hF
) (
  input  logic                i_CLK,
  input  logic                i_Rst_n,
  input  logic                i_En,
  input  logic                i_Hold,
  input  logic                i_Clr,
  input  logic                i_Ovf,
  input  logic [4*DIGITS-1:0] i_Count,
  output logic [4*DIGITS-1:0] o_Q,
  output logic                o_Valid,
  output logic                o_Ovl,
  output logic                o_Err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] reset_pattern();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < DIGITS; i++)
      p[i*4 +: 4] = (i == 0 || !LZB) ? 4'h0 : BLANK_CODE;
    return p;
  endfunction

  function automatic logic [W-1:0] overload_pattern();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < DIGITS; i++)
      p[i*4 +: 4] = (i == DIGITS - 1) ? OVL_TOP : OVL_FILL;
    return p;
  endfunction

  localparam logic [W-1:0] RESET_Q = reset_pattern();
  localparam logic [W-1:0] OVL_Q   = overload_pattern();

  typedef enum logic {S_RUN, S_OVL} state_t;

  state_t       state, state_next;
  logic [W-1:0] q_next;
  logic         valid_next, ovl_next, err_next;
  logic         any_bad, all_nine, accept, overload;
  logic [W-1:0] blanked;

  // Scan from the MSD down; digits stay blank until the first nonzero one.
  always_comb begin
    logic seen;
    any_bad  = 1'b0;
    all_nine = 1'b1;
    blanked  = i_Count;
    seen     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_Count[i*4 +: 4] > 4'd9)  any_bad  = 1'b1;
      if (i_Count[i*4 +: 4] != 4'd9) all_nine = 1'b0;
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (i_Count[i*4 +: 4] != 4'd0) seen = 1'b1;
      if (LZB && !seen) blanked[i*4 +: 4] = BLANK_CODE;
    end
  end

  assign accept   = i_En && !i_Hold && !i_Clr && (state == S_RUN);
  assign overload = all_nine || i_Ovf;

  always_ff @(posedge i_CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= S_RUN;
      o_Q     <= RESET_Q;
      o_Valid <= 1'b0;
      o_Ovl   <= 1'b0;
      o_Err   <= 1'b0;
    end else begin
      state   <= state_next;
      o_Q     <= q_next;
      o_Valid <= valid_next;
      o_Ovl   <= ovl_next;
      o_Err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_Clr)
      state_next = S_RUN;
    else if (accept && !any_bad && overload)
      state_next = S_OVL;
  end

  always_comb begin
    q_next     = o_Q;
    valid_next = 1'b0;
    ovl_next   = o_Ovl;
    err_next   = o_Err;
    if (i_Clr) begin
      q_next   = RESET_Q;
      ovl_next = 1'b0;
      err_next = 1'b0;
    end else if (accept) begin
      if (any_bad) begin
        err_next = 1'b1;
      end else if (overload) begin
        q_next     = OVL_Q;
        ovl_next   = 1'b1;
        valid_next = 1'b1;
      end else begin
        q_next     = blanked;
        valid_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_latch.sv
// Scoreboard bench for bcd_display_latch: three builds (4 digits/LZB, 4 digits raw,
// 6 digits/LZB); strobes push expected codes, a negedge monitor pops on o_Valid.
module tb_bcd_display_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, clr, ovf;
  logic        en_a, en_b, en_c;
  logic [15:0] count_a, count_b;
  logic [23:0] count_c;
  logic [15:0] q_a, q_b;
  logic [23:0] q_c;
  logic        valid_a, valid_b, valid_c;
  logic        ovl_a, ovl_b, ovl_c;
  logic        err_a, err_b, err_c;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];

  always #5 clk = ~clk;

  bcd_display_latch #(.DIGITS(4), .LZB(1'b1)) dut_a (
    .i_CLK(clk), .i_Rst_n(rst_n), .i_En(en_a), .i_Hold(hold), .i_Clr(clr),
    .i_Ovf(ovf), .i_Count(count_a), .o_Q(q_a), .o_Valid(valid_a),
    .o_Ovl(ovl_a), .o_Err(err_a));

  bcd_display_latch #(.DIGITS(4), .LZB(1'b0)) dut_b (
    .i_CLK(clk), .i_Rst_n(rst_n), .i_En(en_b), .i_Hold(hold), .i_Clr(clr),
    .i_Ovf(ovf), .i_Count(count_b), .o_Q(q_b), .o_Valid(valid_b),
    .o_Ovl(ovl_b), .o_Err(err_b));

  bcd_display_latch #(.DIGITS(6), .LZB(1'b1)) dut_c (
    .i_CLK(clk), .i_Rst_n(rst_n), .i_En(en_c), .i_Hold(hold), .i_Clr(clr),
    .i_Ovf(ovf), .i_Count(count_c), .o_Q(q_c), .o_Valid(valid_c),
    .o_Ovl(ovl_c), .o_Err(err_c));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; returns #1 after the capturing edge.
  task automatic applyStimulus(input int sel, input logic [31:0] count,
                               input logic en, input logic h, input logic c,
                               input logic o, input bit exp_valid,
                               input logic [31:0] exp_q);
    hold = h; clr = c; ovf = o;
    case (sel)
      0: begin en_a = en; count_a = count[15:0]; if (exp_valid) exp_a.push_back(exp_q); end
      1: begin en_b = en; count_b = count[15:0]; if (exp_valid) exp_b.push_back(exp_q); end
      default: begin en_c = en; count_c = count[23:0]; if (exp_valid) exp_c.push_back(exp_q); end
    endcase
    @(posedge clk);
    #1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    hold = 1'b0; clr = 1'b0; ovf = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      if (exp_a.size() == 0) checkOutput("a_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("a_q_on_valid", {16'h0, q_a}, exp_a.pop_front());
    end
    if (valid_b) begin
      if (exp_b.size() == 0) checkOutput("b_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("b_q_on_valid", {16'h0, q_b}, exp_b.pop_front());
    end
    if (valid_c) begin
      if (exp_c.size() == 0) checkOutput("c_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("c_q_on_valid", {8'h0, q_c}, exp_c.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    hold = 1'b0; clr = 1'b0; ovf = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    count_a = '0; count_b = '0; count_c = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q_a", {16'h0, q_a}, 32'h0000_EEE0);
    checkOutput("reset_q_b", {16'h0, q_b}, 32'h0000_0000);
    checkOutput("reset_q_c", {8'h0, q_c}, 32'h00EE_EEE0);
    checkOutput("reset_flags_a", {29'h0, valid_a, ovl_a, err_a}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic captures with blanking, back-to-back strobes
    applyStimulus(0, 32'h0042, 1, 0, 0, 0, 1, 32'hEE42);
    applyStimulus(0, 32'h0100, 1, 0, 0, 0, 1, 32'hE100);
    applyStimulus(0, 32'h9998, 1, 0, 0, 0, 1, 32'h9998);
    checkOutput("no_ovl_9998", {31'h0, ovl_a}, 32'h0);

    // All-nines overload, strobes ignored, then clear
    applyStimulus(0, 32'h9999, 1, 0, 0, 0, 1, 32'h1FFF);
    checkOutput("ovl_set", {31'h0, ovl_a}, 32'h1);
    applyStimulus(0, 32'h0001, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("ovl_frozen_q", {16'h0, q_a}, 32'h1FFF);
    applyStimulus(0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
    checkOutput("clr_q", {16'h0, q_a}, 32'hEEE0);
    checkOutput("clr_ovl", {31'h0, ovl_a}, 32'h0);

    // Non-BCD rejection, sticky error
    applyStimulus(0, 32'h12A4, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("err_q_kept", {16'h0, q_a}, 32'hEEE0);
    checkOutput("err_set", {31'h0, err_a}, 32'h1);
    applyStimulus(0, 32'h0305, 1, 0, 0, 0, 1, 32'hE305);
    checkOutput("err_sticky", {31'h0, err_a}, 32'h1);

    // Hold, then release, then clear beats strobe
    applyStimulus(0, 32'h0777, 1, 1, 0, 0, 0, 32'h0);
    checkOutput("hold_q", {16'h0, q_a}, 32'hE305);
    applyStimulus(0, 32'h0777, 1, 0, 0, 0, 1, 32'hE777);
    applyStimulus(0, 32'h0123, 1, 0, 1, 0, 0, 32'h0);
    checkOutput("clr_wins_q", {16'h0, q_a}, 32'hEEE0);
    checkOutput("clr_wins_err", {31'h0, err_a}, 32'h0);

    // External overload, then zero display
    applyStimulus(0, 32'h0000, 1, 0, 0, 1, 1, 32'h1FFF);
    checkOutput("ext_ovl", {31'h0, ovl_a}, 32'h1);
    applyStimulus(0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
    applyStimulus(0, 32'h0000, 1, 0, 0, 0, 1, 32'hEEE0);

    // Error and overload together
    applyStimulus(0, 32'h0F00, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 32'h9999, 1, 0, 0, 0, 1, 32'h1FFF);
    checkOutput("err_and_ovl", {30'h0, ovl_a, err_a}, 32'h3);

    // Raw-digit and six-digit builds
    applyStimulus(1, 32'h0000, 1, 0, 0, 0, 1, 32'h0000);
    applyStimulus(1, 32'h0042, 1, 0, 0, 0, 1, 32'h0042);
    applyStimulus(2, 32'h000042, 1, 0, 0, 0, 1, 32'hEEEE42);
    applyStimulus(2, 32'h999999, 1, 0, 0, 0, 1, 32'h1FFFFF);
    checkOutput("c_ovl", {31'h0, ovl_c}, 32'h1);

    // Asynchronous reset while dut_a sits in overload
    idle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_q", {16'h0, q_a}, 32'hEEE0);
    checkOutput("async_rst_flags", {30'h0, ovl_a, err_a}, 32'h0);
    checkOutput("async_rst_q_c", {8'h0, q_c}, 32'hEEEEE0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 32'h0007, 1, 0, 0, 0, 1, 32'hEEE7);

    idle();
    idle();
    checkOutput("a_queue_drained", exp_a.size(), 32'd0);
    checkOutput("b_queue_drained", exp_b.size(), 32'd0);
    checkOutput("c_queue_drained", exp_c.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
